uart_rx: RTL

UART receive path for the serial link. It is the counterpart of the existing transmit-side baud generator and uses the same divider constants, frame format (1 start, 8 data LSB-first, 1 stop, no parity) and mid-bit sampling point. It synchronises the asynchronous rs232_rx pin, detects the start edge and runs its own baud counter. It samples each bit at mid-period and delivers the assembled byte with a one-cycle valid strobe to the downstream consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/bps_rx.sv | 51 +++++
 rtl/uart_rx.sv | 120 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types, common to the transmit and receive paths.
package uart_pkg;

    // 50 MHz system clock, 9600 baud
    localparam int BPS_DIV_DEF   = 5208;
    localparam int BPS_DIV_2_DEF = 2604;

    // 1 start + 8 data + 1 stop, no parity
    localparam int FRAME_BITS = 10;

    // Bit index width: 0 = start, 1..8 = data, 9 = stop
    localparam int BIT_W = 4;

    // Index of the last data bit (D7) within the frame
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(FRAME_BITS - 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle: received byte, strobes and busy flag.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/bps_rx.sv
// Receive baud counter: counts bit periods while running and strobes at mid-bit.
// Structured like the transmit-side generator so both ends sample consistently.
module bps_rx
    import uart_pkg::*;
#(
    parameter int BPS_DIV   = BPS_DIV_DEF,
    parameter int BPS_DIV_2 = BPS_DIV_2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    output logic             sample_o,
    output logic [BIT_W-1:0] bit_num_o
);

    localparam logic [15:0] CNT_MAX = 16'(BPS_DIV - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_DIV_2 - 1);

    logic [15:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_num_q, bit_num_d;

    assign sample_o  = run_i && (cnt_q == CNT_MID);
    assign bit_num_o = bit_num_q;

    // Next-state: counter wraps every bit period; both counters sit at 0 while idle
    always_comb begin
        cnt_d     = cnt_q;
        bit_num_d = bit_num_q;
        if (!run_i) begin
            cnt_d     = '0;
            bit_num_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 16'd1;
            if (sample_o) begin
                bit_num_d = bit_num_q + BIT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_num_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_num_q <= bit_num_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, frames 8N1 bytes and reports
// good bytes (rx_valid) or bad stop bits (frame_err) as one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BPS_DIV   = BPS_DIV_DEF,
    parameter int BPS_DIV_2 = BPS_DIV_2_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rs232_rx,
    uart_rx_if.master        rx_if
);

    // Synchroniser (s1, s2) plus previous-value flop (s3) for edge detection.
    // All reset high so an idle-high line never looks like a start edge.
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic start_edge;

    rx_state_e        state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    logic             sample;
    logic [BIT_W-1:0] bit_num;

    assign start_edge = rx_s3_q && !rx_s2_q;

    bps_rx #(
        .BPS_DIV   (BPS_DIV),
        .BPS_DIV_2 (BPS_DIV_2)
    ) u_bps (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q != IDLE),
        .sample_o  (sample),
        .bit_num_o (bit_num)
    );

    // Line conditioning
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rs232_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Frame FSM: next state, shift register, output pulses
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only a 1->0 transition starts a frame; a held-low line does not
                if (start_edge) state_d = START;
            end
            START: begin
                // High at the start mid-point means the edge was a glitch
                if (sample) state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: begin
                if (sample) begin
                    // LSB arrives first, so shift in from the MSB side
                    shreg_d = {rx_s2_q, shreg_q[7:1]};
                    if (bit_num == LAST_DATA_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at the stop mid-point for half a bit of back-to-back margin
                if (sample) begin
                    state_d = IDLE;
                    if (rx_s2_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Frame state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.rx_busy   = busy_q;

endmodule
